// File: rtl/exc_unit.sv
// exc_unit: commit-stage exception/ERET sequencer with irq synchronizer and fetch redirect.
// Sequence is IDLE -> TAKE|ERET -> DRAIN -> REDIR -> IDLE, one cycle per non-idle state.
module exc_unit #(
    parameter logic [31:0] VECTOR_CHK = 32'h00400004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        syscall_i,
    input  logic        break_i,
    input  logic        teq_i,
    input  logic        eret_i,
    input  logic        irq,
    input  logic [31:0] status,
    input  logic [31:0] exc_addr,
    output logic        exception_o,
    output logic        eret_o,
    output logic [4:0]  cause_o,
    output logic [31:0] epc_o,
    output logic        flush_o,
    output logic        stall_o,
    output logic        redirect_o,
    output logic [31:0] redirect_addr_o,
    output logic [15:0] exc_count_o
);
    typedef enum logic [2:0] {IDLE, TAKE, ERET, DRAIN, REDIR} state_t;

    state_t      state_q, state_d;
    logic [2:0]  irq_sync_q;
    logic        irq_pend_q, irq_pend_d;
    logic [4:0]  cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] raddr_q, raddr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        qual, q_sys, q_brk, q_teq, q_irq, take, go_eret, irq_edge;
    logic        unused_status;

    assign unused_status = &{1'b0, status[31:5]};
    assign qual     = (state_q == IDLE) && ex_valid && status[0];
    assign q_sys    = qual && syscall_i && status[1];
    assign q_brk    = qual && break_i && status[2];
    assign q_teq    = qual && teq_i && status[3];
    assign q_irq    = qual && irq_pend_q && status[4];
    assign take     = q_sys || q_brk || q_teq || q_irq;
    assign go_eret  = qual && eret_i && !take;
    // irq_sync_q[1] is the synchronized level, [2] its previous value for edge detection
    assign irq_edge = irq_sync_q[1] && !irq_sync_q[2];

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        epc_d      = epc_q;
        raddr_d    = raddr_q;
        cnt_d      = cnt_q;
        irq_pend_d = irq_edge || (irq_pend_q && !(state_q == TAKE && cause_q == 5'd0));
        case (state_q)
            IDLE: begin
                state_d = take ? TAKE : go_eret ? ERET : IDLE;
                cause_d = !take ? cause_q : q_sys ? 5'd8 : q_brk ? 5'd9 : q_teq ? 5'd13 : 5'd0;
                epc_d   = take ? ex_pc : epc_q;
            end
            TAKE: begin
                state_d = DRAIN;
                raddr_d = exc_addr;
                cnt_d   = cnt_q + 16'd1;
            end
            ERET: begin
                state_d = DRAIN;
                raddr_d = exc_addr;
            end
            DRAIN:   state_d = REDIR;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            irq_sync_q <= 3'b000;
            irq_pend_q <= 1'b0;
            cause_q    <= 5'd0;
            epc_q      <= 32'd0;
            raddr_q    <= 32'd0;
            cnt_q      <= 16'd0;
        end else begin
            state_q    <= state_d;
            irq_sync_q <= {irq_sync_q[1:0], irq};
            irq_pend_q <= irq_pend_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            raddr_q    <= raddr_d;
            cnt_q      <= cnt_d;
        end
    end

    assign exception_o     = state_q == TAKE;
    assign eret_o          = state_q == ERET;
    assign flush_o         = state_q == TAKE || state_q == ERET || state_q == DRAIN;
    assign stall_o         = flush_o;
    assign redirect_o      = state_q == REDIR;
    assign cause_o         = cause_q;
    assign epc_o           = epc_q;
    assign redirect_addr_o = raddr_q;
    assign exc_count_o     = cnt_q;

    // The coprocessor must present the exception vector while an exception is being taken
    vector_ok: assert property (@(posedge clk) disable iff (rst) state_q == TAKE |-> exc_addr == VECTOR_CHK);
endmodule

// File: doc/exc_unit.md
EXC_UNIT -- requirements
Module: exc_unit

Interface
REQ-001 Parameter VECTOR_CHK, default 32'h00400004, exception vector; a bench flags a mismatch if exc_addr differs during a TAKE state.
REQ-002 Port clk  input  1  rising-edge clock; all state in this block updates on posedge.
REQ-003 Port rst  input  1  reset; asynchronous, active-high.
REQ-004 Port ex_valid  input  1  instruction in the commit stage is valid.
REQ-005 Port ex_pc  input  32  PC of the commit-stage instruction.
REQ-006 Ports syscall_i, break_i, teq_i, eret_i  input  1 each  decoded commit-stage instruction flags; teq_i is high only when the trap condition holds.
REQ-007 Port irq  input  1  external interrupt, asynchronous level.
REQ-008 Port status  input  32  coprocessor Status: [0] global enable, [1] syscall, [2] break, [3] teq, [4] interrupt enable.
REQ-009 Port exc_addr  input  32  coprocessor target: EPC while eret_o is high, otherwise the vector.
REQ-010 Ports exception_o, eret_o  output  1 each  one-cycle pulses to the coprocessor.
REQ-011 Ports cause_o  output  5; epc_o  output  32  cause code and PC written to the coprocessor with exception_o.
REQ-012 Ports flush_o, stall_o  output  1 each  pipeline flush and fetch freeze.
REQ-013 Ports redirect_o  output  1; redirect_addr_o  output  32  one-cycle fetch redirect and its target.
REQ-014 Port exc_count_o  output  16  count of exceptions taken.

Function
REQ-015 irq SHALL pass through a 2-flop synchronizer; a rising edge on the synchronized signal SHALL set irq_pend.
REQ-016 FSM states SHALL be IDLE, TAKE, ERET, DRAIN, REDIR; all outputs SHALL be registered or decoded from state and registers only.
REQ-017 An event qualifies only in IDLE with ex_valid=1 and status[0]=1, plus its own enable bit: syscall [1], break [2], teq [3], irq_pend [4].
REQ-018 Priority among qualifying events SHALL be syscall (cause 8) > break (9) > teq (13) > interrupt (0).
REQ-019 When an event qualifies: IDLE->TAKE; cause_o and epc_o <= ex_pc latched at that edge.
REQ-020 If eret_i=1, ex_valid=1, no event qualifies, and the state is IDLE: IDLE->ERET; eret_i SHALL be ignored whenever an event qualifies.
REQ-021 TAKE (1 cycle): exception_o=1, flush_o=1, stall_o=1; redirect_addr_o <= exc_addr at exit; exc_count_o increments, wrapping at 16'hFFFF->0; irq_pend clears if the cause is 0.
REQ-022 ERET (1 cycle): eret_o=1, flush_o=1, stall_o=1; redirect_addr_o <= exc_addr at exit.
REQ-023 TAKE->DRAIN and ERET->DRAIN; DRAIN (1 cycle): flush_o=1, stall_o=1; DRAIN->REDIR.
REQ-024 REDIR (1 cycle): redirect_o=1, stall_o=0, flush_o=0; REDIR->IDLE.
REQ-025 Request inputs SHALL be ignored outside IDLE; an irq edge in any state SHALL still set irq_pend.
REQ-026 irq_pend SHALL remain set while masked, and SHALL be taken on the first qualifying IDLE cycle.
REQ-027 An irq edge coinciding with the clearing of irq_pend SHALL leave irq_pend set.
REQ-028 Latency from the qualifying edge to redirect_o SHALL be exactly 3 cycles.

Reset
REQ-029 On rst: state=IDLE; irq_pend=0; synchronizer=0; exception_o=eret_o=flush_o=stall_o=redirect_o=0; cause_o=0; epc_o=0; redirect_addr_o=0; exc_count_o=0.
REQ-030 rst asserted mid-sequence SHALL abort immediately to the reset values, with no partial redirect.

Verification
REQ-031 Check: status=0x1F, syscall_i=1, ex_pc=0x00400100, exc_addr=0x00400004 -> exception_o pulse, cause_o=8, epc_o=0x00400100, flush 2 cycles, redirect_o to 0x00400004 3 cycles after the qualifying edge, exc_count_o=1.
REQ-032 Check: syscall_i=1 and teq_i=1 with status=0x1F -> cause_o=8; with status=0x1D -> cause_o=9 if break_i=1, else cause_o=13.
REQ-033 Check: eret_i=1, exc_addr=0x00400200 while eret_o is high -> eret_o pulse, no exception_o, redirect_addr_o=0x00400200.
REQ-034 Check: irq pulse while status[4]=0 -> no exception; then set status=0x1F with ex_valid=1 -> TAKE with cause_o=0, irq_pend cleared.
REQ-035 Check: rst asserted during DRAIN -> all outputs 0 next sample, state IDLE, exc_count_o=0.
REQ-036 Check: exc_count_o preloaded to 0xFFFF by 65535 traps, one more trap -> exc_count_o=0.
